param_reg_file: RTL and testbench

//   Parametrised register file: NUM_REGS entries of DATA_WIDTH bits, one write port, two read ports.

---
 rtl/param_reg_file.sv | 46 ++++
 tb/tb_param_reg_file.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/param_reg_file.sv
// param_reg_file: masked-write register file with two combinational read ports, optional bypass and zero entry
module param_reg_file #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS = 4,
  parameter bit BYPASS = 1'b1,
  parameter bit ZERO_REG = 1'b0,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] write_mask,
  input  logic [ADDR_WIDTH-1:0] read_addr_0,
  output logic [DATA_WIDTH-1:0] read_data_0,
  input  logic [ADDR_WIDTH-1:0] read_addr_1,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic                  write_error
);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(NUM_REGS);
  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];
  logic                  r_err;
  logic                  w_wa_ok, w_wr_ok, w_byp, w_ok0, w_ok1;
  logic [DATA_WIDTH-1:0] w_old, w_merged;
  assign w_wa_ok = {1'b0, write_addr} < LIMIT;
  assign w_wr_ok = write_enable && w_wa_ok && !(ZERO_REG && write_addr == '0);
  assign w_old = w_wa_ok ? r_mem[write_addr] : '0;
  assign w_merged = (w_old & ~write_mask) | (write_data & write_mask);
  assign w_byp = BYPASS && w_wr_ok && !reset && !clear;
  assign w_ok0 = {1'b0, read_addr_0} < LIMIT && !(ZERO_REG && read_addr_0 == '0);
  assign w_ok1 = {1'b0, read_addr_1} < LIMIT && !(ZERO_REG && read_addr_1 == '0);
  assign read_data_0 = !w_ok0 ? '0 : (w_byp && read_addr_0 == write_addr) ? w_merged : r_mem[read_addr_0];
  assign read_data_1 = !w_ok1 ? '0 : (w_byp && read_addr_1 == write_addr) ? w_merged : r_mem[read_addr_1];
  assign write_error = r_err;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= write_enable && !w_wa_ok;
      if (w_wr_ok) r_mem[write_addr] <= w_merged;
    end
  end
endmodule

// File: tb/tb_param_reg_file.sv
// tb_param_reg_file: scoreboard bench driving a bypass instance and a 3-entry zero-reg no-bypass instance
module tb_param_reg_file;
  logic clk = 1'b0;
  logic reset, clear, we;
  logic [1:0] wa, ra0, ra1;
  logic [7:0] wd, wm;
  logic [7:0] a_rd0, a_rd1, b_rd0, b_rd1;
  logic a_err, b_err;
  logic done = 1'b0;
  int q_sel[$];
  logic [7:0] q_exp[$];
  string q_name[$];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  param_reg_file #(.DATA_WIDTH(8), .NUM_REGS(4), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .write_enable(we), .write_addr(wa),
    .write_data(wd), .write_mask(wm), .read_addr_0(ra0), .read_data_0(a_rd0),
    .read_addr_1(ra1), .read_data_1(a_rd1), .write_error(a_err));
  param_reg_file #(.DATA_WIDTH(8), .NUM_REGS(3), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .write_enable(we), .write_addr(wa),
    .write_data(wd), .write_mask(wm), .read_addr_0(ra0), .read_data_0(b_rd0),
    .read_addr_1(ra1), .read_data_1(b_rd1), .write_error(b_err));
  function automatic logic [7:0] got(input int sel);
    case (sel)
      0: got = a_rd0;
      1: got = a_rd1;
      2: got = {7'd0, a_err};
      3: got = b_rd0;
      4: got = b_rd1;
      default: got = {7'd0, b_err};
    endcase
  endfunction
  task automatic expect_val(input int sel, input logic [7:0] v, input string name);
    q_sel.push_back(sel);
    q_exp.push_back(v);
    q_name.push_back(name);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    while (q_sel.size() > 0) begin
      int s;
      logic [7:0] e, g;
      string n;
      s = q_sel.pop_front();
      e = q_exp.pop_front();
      n = q_name.pop_front();
      g = got(s);
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL %s: got %h expected %h", n, g, e);
      end
    end
  end
  initial begin
    #20000;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL timeout: sequence did not complete");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end
  initial begin
    reset = 1'b1; clear = 1'b0; we = 1'b0; wa = '0; ra0 = '0; ra1 = '0; wd = '0; wm = '0;
    step();
    reset = 1'b0;
    tests++;
    if (a_err !== 1'b0 || b_err !== 1'b0) begin
      fails++;
      $display("FAIL reset state: a_err %b b_err %b expected 0", a_err, b_err);
    end
    for (int a = 0; a < 4; a++) begin
      ra0 = 2'(a); ra1 = 2'(a);
      expect_val(0, 8'h00, "reset a_rd0");
      expect_val(1, 8'h00, "reset a_rd1");
      expect_val(3, 8'h00, "reset b_rd0");
      expect_val(4, 8'h00, "reset b_rd1");
      expect_val(2, 8'h00, "reset a_err");
      expect_val(5, 8'h00, "reset b_err");
      step();
    end
    we = 1'b1; wa = 2'd1; wd = 8'hAA; wm = 8'hFF;
    step();
    wd = 8'h55; wm = 8'h0F;
    step();
    we = 1'b0; ra0 = 2'd1; ra1 = 2'd1;
    expect_val(0, 8'hA5, "mask a_rd0");
    expect_val(1, 8'hA5, "mask a_rd1");
    expect_val(3, 8'hA5, "mask b_rd0");
    expect_val(4, 8'hA5, "mask b_rd1");
    step();
    we = 1'b1; wa = 2'd2; wd = 8'h3C; wm = 8'hFF; ra0 = 2'd2; ra1 = 2'd0;
    expect_val(0, 8'h3C, "bypass a_rd0");
    expect_val(3, 8'h00, "nobypass b_rd0");
    expect_val(1, 8'h00, "bypass other port a_rd1");
    step();
    we = 1'b0;
    expect_val(0, 8'h3C, "after write a_rd0");
    expect_val(3, 8'h3C, "after write b_rd0");
    step();
    we = 1'b1; wa = 2'd1; wd = 8'h0F; wm = 8'hF0; ra0 = 2'd1;
    expect_val(0, 8'h05, "bypass masked a_rd0");
    expect_val(3, 8'hA5, "nobypass masked b_rd0");
    step();
    we = 1'b0;
    expect_val(0, 8'h05, "masked a_rd0");
    expect_val(3, 8'h05, "masked b_rd0");
    step();
    we = 1'b1; wa = 2'd3; wd = 8'hFF; wm = 8'hFF; ra0 = 2'd3; ra1 = 2'd2;
    expect_val(0, 8'hFF, "bypass a addr3");
    expect_val(3, 8'h00, "oob read b addr3");
    expect_val(5, 8'h00, "oob err not yet");
    step();
    we = 1'b0;
    expect_val(5, 8'h01, "oob err pulse");
    expect_val(2, 8'h00, "a no err addr3");
    expect_val(3, 8'h00, "oob b addr3 after");
    expect_val(4, 8'h3C, "oob b reg2 kept");
    expect_val(0, 8'hFF, "a reg3 written");
    step();
    ra0 = 2'd1;
    expect_val(5, 8'h00, "oob err one cycle");
    expect_val(3, 8'h05, "oob b reg1 kept");
    step();
    we = 1'b1; wa = 2'd0; wd = 8'h77; wm = 8'hFF; ra0 = 2'd0; ra1 = 2'd0;
    expect_val(0, 8'h77, "bypass a reg0");
    expect_val(3, 8'h00, "zero b rd0 same cycle");
    step();
    we = 1'b0;
    expect_val(0, 8'h77, "a reg0 written");
    expect_val(3, 8'h00, "zero b rd0");
    expect_val(4, 8'h00, "zero b rd1");
    expect_val(5, 8'h00, "zero b err");
    step();
    clear = 1'b1; we = 1'b1; wa = 2'd1; wd = 8'h11; wm = 8'hFF; ra0 = 2'd1; ra1 = 2'd2;
    expect_val(0, 8'h05, "clear suppresses bypass");
    expect_val(1, 8'h3C, "clear a_rd1 stored");
    step();
    clear = 1'b0; we = 1'b0;
    for (int a = 0; a < 4; a++) begin
      ra0 = 2'(a); ra1 = 2'(3 - a);
      expect_val(0, 8'h00, "clear a_rd0");
      expect_val(1, 8'h00, "clear a_rd1");
      expect_val(3, 8'h00, "clear b_rd0");
      expect_val(4, 8'h00, "clear b_rd1");
      step();
    end
    we = 1'b1; wa = 2'd2; wd = 8'h99; wm = 8'hFF;
    step();
    reset = 1'b1; wd = 8'h44; ra0 = 2'd2; ra1 = 2'd2;
    expect_val(0, 8'h99, "reset suppresses bypass");
    expect_val(4, 8'h99, "reset b stored");
    step();
    reset = 1'b0; we = 1'b0;
    expect_val(0, 8'h00, "reset mid-write a");
    expect_val(4, 8'h00, "reset mid-write b");
    expect_val(5, 8'h00, "reset b err");
    step();
    @(negedge clk);
    #1;
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
